lanzones_bus_master: RTL and testbench
======================================

Name: lanzones_bus_master

Overview:
- Initiator side of the lanzones memory bus (RRdy/RVld/RAddr/RWData/RWEn/RWStrobe/RData), replacing direct core-to-bus wiring.
- Arbitrates instruction-fetch and load/store requests from the core and formats sub-word data.
- Runs the bus handshake and reports completion or error back to the requesting core port.
- Sits between the lanzones pipeline and the memory responder.

Parameters:
- TIMEOUT, 64, bus cycles in READ without RVld before the read is aborted with an error.
- TW, 7, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- IReq  in  1  fetch request; level, held until IAck.
- IAddr  in  32  fetch byte address; [1:0] must be 0.
- IAck  out  1  one-cycle fetch completion pulse.
- IData  out  32  fetch word; valid with IAck.
- DReq  in  1  load/store request; level, held until DAck.
- DWe  in  1  1 = store, 0 = load.
- DSize  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- DUns  in  1  zero-extend loads when 1, sign-extend when 0.
- DAddr  in  32  data byte address.
- DWData  in  32  store data, right-aligned.
- DAck  out  1  one-cycle data completion pulse.
- DRData  out  32  formatted load data; valid with DAck.
- DErr  out  1  one-cycle pulse with DAck: misaligned access, illegal size, or timeout.
- IErr  out  1  one-cycle pulse with IAck: misaligned fetch or timeout.
- RRdy  out  1  bus read request.
- RVld  in  1  bus read response valid (one-cycle pulse).
- RData  in  32  bus read data; valid while RVld.
- RAddr  out  32  bus word address = byte address >> 2.
- RWData  out  32  bus write data, lane-aligned.
- RWEn  out  1  bus write enable; single cycle, no response.
- RWStrobe  out  4  byte-lane enables for writes.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; timeout counter 0; latched request cleared. An in-flight transaction is abandoned and no ack is produced.
- All bus outputs are registered.

States and transitions:
- IDLE:
  - If DReq and access is illegal or misaligned (half with addr[0]=1, word with addr[1:0]!=0, DSize=3): go to ERR. No bus activity.
  - Else if DReq: latch request fields. A store goes to WRITE; a load goes to READ.
  - Else if IReq: misaligned fetch goes to ERR, otherwise go to READ with source=I.
  - DReq has priority over IReq when both are asserted in the same cycle.
- WRITE:
  - RWEn=1 for exactly one cycle.
  - RAddr=DAddr[31:2].
  - Byte store: RWStrobe = 4'b0001 << addr[1:0]; RWData = byte replicated to all 4 lanes.
  - Half store: RWStrobe = 4'b0011 << addr[1:0]; RWData = half replicated to both halves.
  - Word store: RWStrobe = 4'b1111; RWData = DWData.
  - Next cycle: RWEn=0, DAck=1, return to IDLE.
  - Store latency: accept edge to DAck = 2 cycles.
- READ:
  - RRdy=1 and RAddr is held.
  - On the edge where RVld=1: capture RData, clear RRdy, go to RESP.
  - Counter increments each cycle; at TIMEOUT, clear RRdy and go to ERR.
  - With the standard responder, RVld arrives on the second cycle of READ.
  - RRdy must drop the edge after RVld is seen; a second RVld must never be solicited.
- RESP:
  - Pulse IAck with IData = captured word, or DAck with DRData.
  - Load formatting: lane = addr[1:0]; select byte or half from that lane; extend to 32 bits per DUns.
  - Return to IDLE.
  - Load latency: accept edge to ack = 3 cycles.
- ERR:
  - Pulse the source ack with its Err flag; data outputs = 0.
  - Return to IDLE.
- Other rules:
  - The requester must deassert its request the cycle after its ack. A request still high in IDLE starts a new transaction.
  - RVld arriving outside READ is ignored.
  - Ack and Err outputs are 0 in all states other than RESP and ERR.
  - RWEn and RRdy are never asserted in the same cycle.

Decomposition:
- Package lanzones_bus_pkg holds:
  - state encoding: IDLE, READ, WRITE, RESP, ERR;
  - size constants SZ_B=0, SZ_H=1, SZ_W=2;
  - the default TIMEOUT.
- One sub-module: lanzones_lane_fmt. It is combinational and produces store lane/strobe alignment and load extract/extend, shared by the WRITE and RESP paths.

Test Plan:
- Fetch, IAddr=0x100, memory word 0x40=0x00500093 -> RRdy for 2 cycles, RAddr=0x40, IAck 3 cycles after accept, IData=0x00500093.
- Byte load, DAddr=0x203, DUns=0, memory word 0x80=0x80FF1234 -> DRData=0xFFFFFF80; repeat with DUns=1 -> DRData=0x00000080.
- Half store, DAddr=0x302, DWData=0xBEEF -> one RWEn cycle, RAddr=0xC0, RWStrobe=4'b1100, RWData=0xBEEFBEEF; readback word = old[15:0] | 0xBEEF0000.
- IReq and DReq (word load, 0x10) asserted in the same cycle -> D transaction first; I starts in the IDLE cycle after DAck.
- Word load at DAddr=0x006 -> DAck with DErr=1, no RRdy or RWEn asserted. Responder tied RVld=0 -> DErr after TIMEOUT=64 READ cycles.
- rstn dropped mid-READ -> RRdy=0 asynchronously, no ack; after release, a new fetch completes normally.

Source files
------------

// File: rtl/lanzones_bus_pkg.sv
// Shared types and constants for the lanzones bus initiator.
package lanzones_bus_pkg;

  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, ERR} state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int TIMEOUT_DEF = 64;

  // Size 3 is never legal; halves need even addresses, words need aligned ones.
  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lanzones_lane_fmt.sv
// Combinational byte-lane alignment for stores and extract/extend for loads.
module lanzones_lane_fmt
  import lanzones_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        uns,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_strobe,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte   = ld_word[{lane, 3'b000} +: 8];
    ld_half   = lane[1] ? ld_word[31:16] : ld_word[15:0];
    st_strobe = 4'b1111;
    st_lanes  = st_data;
    ld_data   = ld_word;
    case (size)
      SZ_B: begin
        st_strobe = 4'b0001 << lane;
        st_lanes  = {4{st_data[7:0]}};
        ld_data   = {{24{~uns & ld_byte[7]}}, ld_byte};
      end
      SZ_H: begin
        st_strobe = 4'b0011 << lane;
        st_lanes  = {2{st_data[15:0]}};
        ld_data   = {{16{~uns & ld_half[15]}}, ld_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lanzones_bus_master.sv
// Lanzones bus initiator: arbitrates fetch and load/store ports onto the memory bus.
// state | meaning
// IDLE  | waiting for a request; D port wins over I port
// READ  | RRdy held, waiting for RVld or timeout
// WRITE | single RWEn cycle on the bus
// RESP  | ack the requester with fetched/formatted data
// ERR   | ack the requester with its error flag, data 0
module lanzones_bus_master
  import lanzones_bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = 7
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic        IAck,
  output logic [31:0] IData,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [1:0]  DSize,
  input  logic        DUns,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  output logic        DAck,
  output logic [31:0] DRData,
  output logic        DErr,
  output logic        IErr,
  output logic        RRdy,
  input  logic        RVld,
  input  logic [31:0] RData,
  output logic [31:0] RAddr,
  output logic [31:0] RWData,
  output logic        RWEn,
  output logic [3:0]  RWStrobe
);

  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          src_d_q, src_d_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    lo_q, lo_d;
  logic [31:0]   rword_q, rword_d;
  logic          iack_q, iack_d, ierr_q, ierr_d, dack_q, dack_d, derr_q, derr_d;
  logic [31:0]   idata_q, idata_d, drdata_q, drdata_d;
  logic          rrdy_q, rrdy_d, rwen_q, rwen_d;
  logic [31:0]   raddr_q, raddr_d, rwdata_q, rwdata_d;
  logic [3:0]    rstrb_q, rstrb_d;

  logic [1:0]    fmt_size, fmt_lane;
  logic [3:0]    st_strobe;
  logic [31:0]   st_lanes, ld_data;

  // Store alignment happens at accept from live inputs; load formatting later from latched fields.
  assign fmt_size = (state_q == IDLE) ? DSize : size_q;
  assign fmt_lane = (state_q == IDLE) ? DAddr[1:0] : lo_q;

  lanzones_lane_fmt u_fmt (
    .size      (fmt_size),
    .lane      (fmt_lane),
    .uns       (uns_q),
    .st_data   (DWData),
    .ld_word   (rword_q),
    .st_strobe (st_strobe),
    .st_lanes  (st_lanes),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    src_d_d  = src_d_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    lo_d     = lo_q;
    rword_d  = rword_q;
    raddr_d  = raddr_q;
    rrdy_d   = rrdy_q;
    iack_d   = 1'b0;
    ierr_d   = 1'b0;
    idata_d  = '0;
    dack_d   = 1'b0;
    derr_d   = 1'b0;
    drdata_d = '0;
    rwen_d   = 1'b0;
    rwdata_d = '0;
    rstrb_d  = '0;
    case (state_q)
      IDLE: begin
        if (DReq) begin
          src_d_d = 1'b1;
          we_d    = DWe;
          size_d  = DSize;
          uns_d   = DUns;
          lo_d    = DAddr[1:0];
          if (bad_access(DSize, DAddr[1:0])) begin
            state_d = ERR;
          end else if (DWe) begin
            state_d  = WRITE;
            rwen_d   = 1'b1;
            raddr_d  = {2'b00, DAddr[31:2]};
            rwdata_d = st_lanes;
            rstrb_d  = st_strobe;
          end else begin
            state_d = READ;
            rrdy_d  = 1'b1;
            raddr_d = {2'b00, DAddr[31:2]};
            cnt_d   = TW'(TIMEOUT - 1);
          end
        end else if (IReq) begin
          src_d_d = 1'b0;
          we_d    = 1'b0;
          size_d  = SZ_W;
          uns_d   = 1'b0;
          lo_d    = IAddr[1:0];
          if (|IAddr[1:0]) begin
            state_d = ERR;
          end else begin
            state_d = READ;
            rrdy_d  = 1'b1;
            raddr_d = {2'b00, IAddr[31:2]};
            cnt_d   = TW'(TIMEOUT - 1);
          end
        end
      end
      READ: begin
        if (RVld) begin
          rword_d = RData;
          rrdy_d  = 1'b0;
          state_d = RESP;
        end else if (cnt_q == '0) begin
          rrdy_d  = 1'b0;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (src_d_q) begin
          dack_d   = 1'b1;
          drdata_d = we_q ? '0 : ld_data;
        end else begin
          iack_d  = 1'b1;
          idata_d = rword_q;
        end
        state_d = IDLE;
      end
      ERR: begin
        dack_d  = src_d_q;
        derr_d  = src_d_q;
        iack_d  = ~src_d_q;
        ierr_d  = ~src_d_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      src_d_q  <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      lo_q     <= '0;
      rword_q  <= '0;
      raddr_q  <= '0;
      rrdy_q   <= 1'b0;
      iack_q   <= 1'b0;
      ierr_q   <= 1'b0;
      idata_q  <= '0;
      dack_q   <= 1'b0;
      derr_q   <= 1'b0;
      drdata_q <= '0;
      rwen_q   <= 1'b0;
      rwdata_q <= '0;
      rstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      src_d_q  <= src_d_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      lo_q     <= lo_d;
      rword_q  <= rword_d;
      raddr_q  <= raddr_d;
      rrdy_q   <= rrdy_d;
      iack_q   <= iack_d;
      ierr_q   <= ierr_d;
      idata_q  <= idata_d;
      dack_q   <= dack_d;
      derr_q   <= derr_d;
      drdata_q <= drdata_d;
      rwen_q   <= rwen_d;
      rwdata_q <= rwdata_d;
      rstrb_q  <= rstrb_d;
    end
  end

  assign IAck     = iack_q;
  assign IErr     = ierr_q;
  assign IData    = idata_q;
  assign DAck     = dack_q;
  assign DErr     = derr_q;
  assign DRData   = drdata_q;
  assign RRdy     = rrdy_q;
  assign RAddr    = raddr_q;
  assign RWEn     = rwen_q;
  assign RWData   = rwdata_q;
  assign RWStrobe = rstrb_q;

endmodule

// File: tb/tb_lanzones_bus_master.sv
// Directed bench for lanzones_bus_master with a two-cycle-latency memory responder.
module tb_lanzones_bus_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        IReq = 1'b0, DReq = 1'b0, DWe = 1'b0, DUns = 1'b0, RVld = 1'b0;
  logic [31:0] IAddr = '0, DAddr = '0, DWData = '0, RData = '0;
  logic [1:0]  DSize = '0;
  logic        IAck, DAck, DErr, IErr, RRdy, RWEn;
  logic [31:0] IData, DRData, RAddr, RWData;
  logic [3:0]  RWStrobe;

  int n_assert = 0;
  int n_fail = 0;

  logic [31:0] mem [0:255];
  bit          tie_off = 1'b0;
  int          rcnt = 0;

  logic        c_iack, c_dack, c_ierr, c_derr;
  logic [31:0] c_idata, c_drdata, c_raddr, c_wdata;
  logic [3:0]  c_strb;
  int          lat, nrr, nwe;

  lanzones_bus_master #(.TIMEOUT(64), .TW(7)) dut (
    .clk(clk), .rstn(rstn),
    .IReq(IReq), .IAddr(IAddr), .IAck(IAck), .IData(IData),
    .DReq(DReq), .DWe(DWe), .DSize(DSize), .DUns(DUns), .DAddr(DAddr), .DWData(DWData),
    .DAck(DAck), .DRData(DRData), .DErr(DErr), .IErr(IErr),
    .RRdy(RRdy), .RVld(RVld), .RData(RData), .RAddr(RAddr),
    .RWData(RWData), .RWEn(RWEn), .RWStrobe(RWStrobe)
  );

  always #5 clk = ~clk;

  // Responder: RVld pulses on the second cycle RRdy is seen high; writes land in mem.
  always @(posedge clk) begin
    #1;
    if (RWEn)
      for (int b = 0; b < 4; b++)
        if (RWStrobe[b]) mem[RAddr[7:0]][8*b +: 8] = RWData[8*b +: 8];
    if (RVld) RVld = 1'b0;
    if (RRdy) rcnt++; else rcnt = 0;
    if (rcnt == 2 && !tie_off) begin
      RVld  = 1'b1;
      RData = mem[RAddr[7:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic d_req(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    DWe = we; DSize = size; DUns = uns; DAddr = addr; DWData = wdata; DReq = 1'b1;
  endtask

  task automatic wait_ack(output int l, output int r, output int w);
    l = -1; r = 0; w = 0;
    for (int t = 0; t < 200; t++) begin
      tick();
      if (RRdy) begin r++; c_raddr = RAddr; end
      if (RWEn) begin w++; c_raddr = RAddr; c_wdata = RWData; c_strb = RWStrobe; end
      if (IAck || DAck) begin
        l = t;
        c_iack = IAck; c_dack = DAck; c_ierr = IErr; c_derr = DErr;
        c_idata = IData; c_drdata = DRData;
        break;
      end
    end
    n_assert++;
    assert (l >= 0)
    else begin
      n_fail++;
      $error("FAIL ack_wait: observed no ack in 200 cycles, expected an ack");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 32'h00500093;
    mem[8'h80] = 32'h80FF1234;
    mem[8'hC0] = 32'h12345678;
    mem[8'h04] = 32'hCAFEF00D;

    tick(); tick();
    chk("rst_rrdy", {31'd0, RRdy}, 32'd0);
    chk("rst_rwen", {31'd0, RWEn}, 32'd0);
    chk("rst_acks", {28'd0, IAck, DAck, IErr, DErr}, 32'd0);
    chk("rst_raddr", RAddr, 32'd0);
    rstn = 1'b1;
    tick();

    IAddr = 32'h100; IReq = 1'b1;
    wait_ack(lat, nrr, nwe); IReq = 1'b0;
    chk("fetch_lat", lat, 3);
    chk("fetch_rrdy_cycles", nrr, 2);
    chk("fetch_raddr", c_raddr, 32'h40);
    chk("fetch_iack_ierr", {30'd0, c_iack, c_ierr}, 32'd2);
    chk("fetch_data", c_idata, 32'h00500093);
    tick();
    chk("ack_one_cycle", {30'd0, IAck, DAck}, 32'd0);

    d_req(1'b0, 2'd0, 1'b0, 32'h203, '0);
    wait_ack(lat, nrr, nwe); DReq = 1'b0;
    chk("lb_lat", lat, 3);
    chk("lb_signed", c_drdata, 32'hFFFFFF80);
    chk("lb_derr", {31'd0, c_derr}, 32'd0);
    d_req(1'b0, 2'd0, 1'b1, 32'h203, '0);
    wait_ack(lat, nrr, nwe); DReq = 1'b0;
    chk("lbu_unsigned", c_drdata, 32'h00000080);

    d_req(1'b1, 2'd1, 1'b0, 32'h302, 32'h0000BEEF);
    wait_ack(lat, nrr, nwe); DReq = 1'b0;
    chk("sh_lat", lat, 2);
    chk("sh_rwen_cycles", nwe, 1);
    chk("sh_no_rrdy", nrr, 0);
    chk("sh_raddr", c_raddr, 32'hC0);
    chk("sh_strobe", {28'd0, c_strb}, 32'hC);
    chk("sh_wdata", c_wdata, 32'hBEEFBEEF);
    chk("sh_ack", {30'd0, c_dack, c_derr}, 32'd2);
    d_req(1'b0, 2'd2, 1'b0, 32'h300, '0);
    wait_ack(lat, nrr, nwe); DReq = 1'b0;
    chk("sh_readback", c_drdata, 32'hBEEF5678);
    d_req(1'b0, 2'd1, 1'b0, 32'h302, '0);
    wait_ack(lat, nrr, nwe); DReq = 1'b0;
    chk("lh_signed", c_drdata, 32'hFFFFBEEF);

    d_req(1'b1, 2'd0, 1'b0, 32'h301, 32'h000000A5);
    wait_ack(lat, nrr, nwe); DReq = 1'b0;
    chk("sb_strobe", {28'd0, c_strb}, 32'h2);
    chk("sb_wdata", c_wdata, 32'hA5A5A5A5);
    d_req(1'b0, 2'd2, 1'b0, 32'h300, '0);
    wait_ack(lat, nrr, nwe); DReq = 1'b0;
    chk("sb_readback", c_drdata, 32'hBEEFA578);

    IAddr = 32'h100; IReq = 1'b1;
    d_req(1'b0, 2'd2, 1'b0, 32'h10, '0);
    wait_ack(lat, nrr, nwe); DReq = 1'b0;
    chk("prio_d_first", {30'd0, c_iack, c_dack}, 32'd1);
    chk("prio_d_data", c_drdata, 32'hCAFEF00D);
    wait_ack(lat, nrr, nwe); IReq = 1'b0;
    chk("prio_i_second", {30'd0, c_iack, c_dack}, 32'd2);
    chk("prio_i_lat", lat, 3);
    chk("prio_i_data", c_idata, 32'h00500093);

    d_req(1'b0, 2'd2, 1'b0, 32'h006, '0);
    wait_ack(lat, nrr, nwe); DReq = 1'b0;
    chk("mis_derr", {30'd0, c_dack, c_derr}, 32'd3);
    chk("mis_data", c_drdata, 32'd0);
    chk("mis_no_bus", nrr + nwe, 0);
    chk("mis_lat", lat, 1);

    d_req(1'b0, 2'd3, 1'b0, 32'h0, '0);
    wait_ack(lat, nrr, nwe); DReq = 1'b0;
    chk("size3_derr", {30'd0, c_dack, c_derr}, 32'd3);

    IAddr = 32'h102; IReq = 1'b1;
    wait_ack(lat, nrr, nwe); IReq = 1'b0;
    chk("imis_ierr", {30'd0, c_iack, c_ierr}, 32'd3);
    chk("imis_data", c_idata, 32'd0);

    tie_off = 1'b1;
    d_req(1'b0, 2'd2, 1'b0, 32'h0, '0);
    wait_ack(lat, nrr, nwe); DReq = 1'b0;
    tie_off = 1'b0;
    chk("tmo_derr", {30'd0, c_dack, c_derr}, 32'd3);
    chk("tmo_rrdy_cycles", nrr, 64);
    chk("tmo_lat", lat, 65);

    IAddr = 32'h100; IReq = 1'b1;
    tick(); tick();
    chk("rstmid_rrdy_before", {31'd0, RRdy}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("rstmid_rrdy_async", {31'd0, RRdy}, 32'd0);
    IReq = 1'b0;
    tick();
    chk("rstmid_no_ack", {30'd0, IAck, DAck}, 32'd0);
    rstn = 1'b1;
    tick(); tick();
    chk("rstmid_idle_ack", {30'd0, IAck, DAck}, 32'd0);
    IAddr = 32'h100; IReq = 1'b1;
    wait_ack(lat, nrr, nwe); IReq = 1'b0;
    chk("post_rst_lat", lat, 3);
    chk("post_rst_data", c_idata, 32'h00500093);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
